// File: rtl/fmul_pkg.sv
// Shared types and constants for the FMUL32 operand issue path.
package fmul_pkg;

    typedef logic [1:0] opc_t;
    typedef logic [1:0] rmode_t;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } issue_state_t;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        opc_t        opc;
        rmode_t      rmode;
    } req_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fmul_issue_ctrl_if.sv
// Request, FMUL32 and response signals of the issue controller, with both-side views.
interface fmul_issue_ctrl_if;
    import fmul_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    opc_t        in_opc;
    rmode_t      in_rmode;

    logic [31:0] fm_op1;
    logic [31:0] fm_op2;
    opc_t        fm_opc;
    rmode_t      fm_rmode;
    logic [31:0] fm_result;
    logic        fm_val;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    opc_t        out_opc;
    logic        out_err;
    logic [7:0]  err_cnt;

    // Controller side.
    modport slave (
        input  in_valid, in_op1, in_op2, in_opc, in_rmode,
        input  fm_result, fm_val,
        input  out_ready,
        output in_ready,
        output fm_op1, fm_op2, fm_opc, fm_rmode,
        output out_valid, out_result, out_opc, out_err, err_cnt
    );

    // Requester / FMUL32 / consumer side.
    modport master (
        output in_valid, in_op1, in_op2, in_opc, in_rmode,
        output fm_result, fm_val,
        output out_ready,
        input  in_ready,
        input  fm_op1, fm_op2, fm_opc, fm_rmode,
        input  out_valid, out_result, out_opc, out_err, err_cnt
    );

endinterface

// File: rtl/fmul_op_fifo.sv
// Synchronous operand FIFO of req_t entries; no bypass, push refused while full.
module fmul_op_fifo
    import fmul_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  req_t                     data_i,
    input  logic                     pop_i,
    output req_t                     data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    req_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign push = push_i && !full_o;
    assign pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fmul_issue_ctrl.sv
// Buffers operand pairs and issues them one at a time to FMUL32, returning each result
// (or a qNaN timeout abort) in request order on the response stream.
module fmul_issue_ctrl
    import fmul_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    fmul_issue_ctrl_if.slave bus_io
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    issue_state_t  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    req_t          fm_req_q, fm_req_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_result_q, out_result_d;
    opc_t          out_opc_q, out_opc_d;
    logic          out_err_q, out_err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    req_t          fifo_in;
    req_t          fifo_head;
    logic          fifo_push, fifo_pop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    assign fifo_in = '{op1:   bus_io.in_op1,
                       op2:   bus_io.in_op2,
                       opc:   bus_io.in_opc,
                       rmode: bus_io.in_rmode};

    assign fifo_push       = bus_io.in_valid && !fifo_full;
    assign bus_io.in_ready = (fifo_count != CW'(DEPTH));

    fmul_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        fm_req_d     = fm_req_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_opc_d    = out_opc_q;
        out_err_d    = out_err_q;
        err_cnt_d    = err_cnt_q;
        fifo_pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    fm_req_d = fifo_head;
                    timer_d  = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // fm_val in the first WAIT cycle may belong to the previous request.
                if (bus_io.fm_val && (timer_q != '0)) begin
                    out_result_d = bus_io.fm_result;
                    out_opc_d    = fm_req_q.opc;
                    out_err_d    = 1'b0;
                    out_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if (timer_q == TIMER_LAST) begin
                    out_result_d = FP32_QNAN;
                    out_opc_d    = fm_req_q.opc;
                    out_err_d    = 1'b1;
                    out_valid_d  = 1'b1;
                    err_cnt_d    = sat_inc8(err_cnt_q);
                    state_d      = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                if (bus_io.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            fm_req_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_opc_q    <= '0;
            out_err_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            fm_req_q     <= fm_req_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_opc_q    <= out_opc_d;
            out_err_q    <= out_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus_io.fm_op1     = fm_req_q.op1;
    assign bus_io.fm_op2     = fm_req_q.op2;
    assign bus_io.fm_opc     = fm_req_q.opc;
    assign bus_io.fm_rmode   = fm_req_q.rmode;
    assign bus_io.out_valid  = out_valid_q;
    assign bus_io.out_result = out_result_q;
    assign bus_io.out_opc    = out_opc_q;
    assign bus_io.out_err    = out_err_q;
    assign bus_io.err_cnt    = err_cnt_q;

endmodule

// File: doc/fmul_issue_ctrl.md
Name: fmul_issue_ctrl

Overview:
- Upstream operand issuer for the FMUL32 single-precision multiplier.
- Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Issues one request at a time to FMUL32, holding op1/op2/opc/r_mode stable until FMUL32 asserts val.
- Returns each result on a valid/ready response stream, with a timeout guard and error counter.

Parameters:
- DEPTH, 4, operand FIFO entries (power of two, >= 2).
- TIMEOUT, 16, max cycles spent in WAIT before a request is aborted (>= 2).

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_op1  input  32  FP32 operand 1
- in_op2  input  32  FP32 operand 2
- in_opc  input  2  FMUL32 opcode
- in_rmode  input  2  rounding mode
- fm_op1  output  32  to FMUL32 op1
- fm_op2  output  32  to FMUL32 op2
- fm_opc  output  2  to FMUL32 opc
- fm_rmode  output  2  to FMUL32 r_mode
- fm_result  input  32  FMUL32 result
- fm_val  input  1  FMUL32 val
- out_valid  output  1  response valid
- out_ready  input  1  response consumed when out_valid && out_ready
- out_result  output  32  captured result, or qNaN on timeout
- out_opc  output  2  opcode of the request that produced this response
- out_err  output  1  response is a timeout abort
- err_cnt  output  8  count of timeouts, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=1 after reset; all other outputs 0; FIFO empty; state IDLE; timer 0.
- Reset mid-operation: the in-flight request and all FIFO contents are discarded. An fm_val arriving after reset is ignored.
- FIFO push and in_ready:
  - Push when in_valid && in_ready.
  - in_ready = !full, registered-count based.
  - No push while full, even if a pop occurs in the same cycle.
  - No bypass: a push into an empty FIFO becomes visible to the FSM on the next cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If the FIFO is non-empty: pop the head and register it into fm_op1/fm_op2/fm_opc/fm_rmode.
  - Clear the timer and go to WAIT.
  - Otherwise hold. fm_* keep their last values.
- WAIT:
  - The timer increments every cycle.
  - fm_val is ignored in the first WAIT cycle (timer==0), so a stale val from the previous request cannot complete the new one.
  - If fm_val && timer>=1: out_result<=fm_result, out_opc<=fm_opc, out_err<=0, out_valid<=1, go to RESP.
  - Else if timer==TIMEOUT-1: out_result<=32'h7FC00000, out_err<=1, out_valid<=1, err_cnt+=1 (saturating at 255), go to RESP.
  - If fm_val arrives in the same cycle the timer reaches TIMEOUT-1, the valid result wins.
- RESP:
  - out_valid, out_result, out_opc and out_err are held stable until out_ready.
  - On handshake: out_valid<=0, go to IDLE.
  - fm_* stay held through RESP.
- Latency and throughput:
  - Minimum latency from FIFO head to out_valid: 3 cycles (IDLE pop, WAIT timer 0, WAIT capture).
  - Maximum throughput: one request per 4 cycles.
- Ordering: responses are returned strictly in request order.
- Arithmetic: the timer is clog2(TIMEOUT) bits wide and never wraps, because it is cleared on entry to WAIT.

Decomposition:
- Shared package fmul_pkg holds:
  - opc_t (2-bit), rmode_t (2-bit)
  - FP32_QNAN = 32'h7FC00000
  - issue_state_t enum {IDLE, WAIT, RESP}
  - req_t struct {op1, op2, opc, rmode}
- One sub-module: fmul_op_fifo, a synchronous FIFO of req_t with parameter DEPTH and outputs full/empty/count.
- The FSM, timer and response registers stay in fmul_issue_ctrl.

Test Plan:
- Single request: in_op1=3F800000, in_op2=40000000, opc=0; FMUL32 model asserts val with 40000000 two cycles after issue; out_ready=1. Required: out_result=40000000, out_err=0, out_valid exactly 1 cycle, err_cnt=0.
- Back-pressure: push 5 requests back-to-back with out_ready=0 and DEPTH=4. Required: in_ready drops after 4 accepted entries (the first has already been popped into WAIT); after releasing out_ready, 5 responses return in order with matching out_opc.
- Timeout: the model never asserts val. Required: out_valid in the cycle after timer reaches 15; out_result=7FC00000; out_err=1; err_cnt=1. A following normal request completes correctly.
- Stale val: fm_val held high continuously. Required: each request still spends at least 2 WAIT cycles, and no response precedes its own issue.
- Reset mid-WAIT: assert rst for 1 cycle with 2 entries queued and one in flight; then pulse fm_val. Required: out_valid stays 0, in_ready=1, the FIFO is empty, and err_cnt is unchanged at 0.
- err_cnt saturation: 260 consecutive timeouts. Required: err_cnt=255 and no wrap.
